// File: rtl/regfile_pkg.sv
// Shared types for the register file: architectural sizes (common) and the
// writeback stage's commit record (pipes).
package common;
  localparam int XLEN = 64;
  localparam int NREG = 32;

  typedef logic [4:0]      creg_addr_t;
  typedef logic [XLEN-1:0] word_t;
endpackage

package pipes;
  import common::*;

  typedef struct packed {
    logic regwrite;
  } wb_ctl_t;

  typedef struct packed {
    creg_addr_t dst;
    word_t      writedata;
    wb_ctl_t    ctl;
  } writeback_data_t;

  function automatic logic wb_writes(writeback_data_t wb);
    return wb.ctl.regwrite && (wb.dst != '0);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters with saturating issue, floor-at-zero
// retire, synchronous flush and a sticky overflow flag.
module regfile_scoreboard #(
  parameter int NREG   = 32,
  parameter int PEND_W = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               issue_valid,
  input  common::creg_addr_t issue_dst,
  input  logic               wb_en,
  input  common::creg_addr_t wb_dst,
  input  logic               flush,
  output logic [NREG-1:0]    busy_now,
  output logic [NREG-1:0]    busy_post,
  output logic               sb_overflow
);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [NREG-1:0] ovf_bits;
  logic            ovf_q, ovf_d;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              inc, dec, ovf_set;

    always_comb begin
      inc     = issue_valid && (issue_dst == common::creg_addr_t'(i)) && (i != 0);
      dec     = wb_en && (wb_dst == common::creg_addr_t'(i));
      pend_d  = pend_q;
      ovf_set = 1'b0;
      if (inc && !dec) begin
        if (pend_q == PEND_MAX) ovf_set = 1'b1;
        else                    pend_d  = pend_q + PEND_W'(1);
      end else if (dec && !inc && pend_q != '0) begin
        pend_d = pend_q - PEND_W'(1);
      end
      if (flush) pend_d = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) pend_q <= '0;
      else         pend_q <= pend_d;
    end

    assign busy_now[i]  = (pend_q != '0);
    // Count as it will stand once this cycle's retire lands.
    assign busy_post[i] = dec ? (pend_q > PEND_W'(1)) : (pend_q != '0);
    assign ovf_bits[i]  = ovf_set;
  end

  assign ovf_d = ovf_q | (|ovf_bits);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign sb_overflow = ovf_q;
endmodule

// File: rtl/regfile.sv
// Architectural register file with two combinational read ports and a
// pending-write scoreboard. REGFILE_BYPASS_EN forwards writeback data/retire.
module regfile
  import pipes::*;
#(
  parameter int NREG   = common::NREG,
  parameter int XLEN   = common::XLEN,
  parameter int PEND_W = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  writeback_data_t    dataW,
  input  common::creg_addr_t ra1,
  input  common::creg_addr_t ra2,
  output logic [XLEN-1:0]    rd1,
  output logic [XLEN-1:0]    rd2,
  output logic               busy1,
  output logic               busy2,
  input  logic               issue_valid,
  input  common::creg_addr_t issue_dst,
  input  logic               flush,
  output logic               sb_overflow
);
  localparam int NPORT = 2;

  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
  logic                      wb_en;
  logic [NREG-1:0]           busy_now, busy_post;

  logic [NPORT-1:0][4:0]      ra_v;
  logic [NPORT-1:0][XLEN-1:0] rd_v;
  logic [NPORT-1:0]           busy_v;

  assign wb_en = wb_writes(dataW);

  always_comb begin
    regs_d = regs_q;
    if (wb_en) regs_d[dataW.dst] = dataW.writedata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) regs_q <= '0;
    else         regs_q <= regs_d;
  end

  regfile_scoreboard #(.NREG(NREG), .PEND_W(PEND_W)) u_sb (
    .clk         (clk),
    .resetn      (resetn),
    .issue_valid (issue_valid),
    .issue_dst   (issue_dst),
    .wb_en       (wb_en),
    .wb_dst      (dataW.dst),
    .flush       (flush),
    .busy_now    (busy_now),
    .busy_post   (busy_post),
    .sb_overflow (sb_overflow)
  );

  assign ra_v = {ra2, ra1};

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic [XLEN-1:0] rd_p;
    logic            busy_p;

    always_comb begin
      rd_p = regs_q[ra_v[p]];
`ifdef REGFILE_BYPASS_EN
      busy_p = busy_post[ra_v[p]];
      if (wb_en && dataW.dst == ra_v[p]) rd_p = dataW.writedata;
`else
      busy_p = busy_now[ra_v[p]];
`endif
      // Outputs are forced quiet during reset, including any bypass path.
      if (!resetn || ra_v[p] == '0) begin
        rd_p   = '0;
        busy_p = 1'b0;
      end
    end

    assign rd_v[p]   = rd_p;
    assign busy_v[p] = busy_p;
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_post;
  assign unused_post = ^busy_post;
`endif

  assign rd1   = rd_v[0];
  assign rd2   = rd_v[1];
  assign busy1 = busy_v[0];
  assign busy2 = busy_v[1];
endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expectations follow the
// REGFILE_BYPASS_EN setting of the build.
module tb_regfile;
  import pipes::*;

  logic               clk = 1'b0;
  logic               resetn;
  writeback_data_t    dataW;
  common::creg_addr_t ra1, ra2, issue_dst;
  logic [63:0]        rd1, rd2;
  logic               busy1, busy2, issue_valid, flush, sb_overflow;

  int total = 0;
  int bad   = 0;

  regfile dut (
    .clk(clk), .resetn(resetn), .dataW(dataW),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2),
    .issue_valid(issue_valid), .issue_dst(issue_dst),
    .flush(flush), .sb_overflow(sb_overflow)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dataW       = '0;
    issue_valid = 1'b0;
    issue_dst   = '0;
    flush       = 1'b0;
  endtask

  task automatic wb(input logic [4:0] dst, input logic [63:0] d);
    dataW.dst          = dst;
    dataW.writedata    = d;
    dataW.ctl.regwrite = 1'b1;
  endtask

  task automatic test_reset();
    logic [63:0] a;
    a = 64'h1234_5678_9ABC_DEF0;
    // outputs quiet while held in reset
    ra1 = 5'd5; ra2 = 5'd31; #1;
    total++; if (rd1 !== 64'd0 || rd2 !== 64'd0) begin bad++; $display("FAIL reset_hold_rd rd1=%h rd2=%h want 0", rd1, rd2); end
    total++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin bad++; $display("FAIL reset_hold_busy b1=%b b2=%b want 0", busy1, busy2); end
    tick(); resetn = 1'b1; tick();
    wb(5'd5, a); issue_valid = 1'b1; issue_dst = 5'd31;
    tick(); idle(); #1;
    total++; if (rd1 !== a) begin bad++; $display("FAIL pre_reset_rd1 got=%h want=%h", rd1, a); end
    total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL pre_reset_busy2 got=%b want=1", busy2); end
    resetn = 1'b0; #1;
    total++; if (rd1 !== 64'd0 || rd2 !== 64'd0) begin bad++; $display("FAIL reset_pulse_rd rd1=%h rd2=%h want 0", rd1, rd2); end
    total++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin bad++; $display("FAIL reset_pulse_busy b1=%b b2=%b want 0", busy1, busy2); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic [63:0] d;
    d = 64'hDEAD_BEEF_0000_0001;
    ra1 = 5'd3; wb(5'd3, d); #1;
    total++; if (rd1 !== (BYP ? d : 64'd0)) begin bad++; $display("FAIL wr_same_cycle got=%h want=%h", rd1, BYP ? d : 64'd0); end
    tick(); idle(); #1;
    total++; if (rd1 !== d) begin bad++; $display("FAIL wr_next_cycle got=%h want=%h", rd1, d); end
    ra2 = 5'd3; wb(5'd3, 64'h5555_AAAA_5555_AAAA); #1;
    total++; if (rd2 !== (BYP ? 64'h5555_AAAA_5555_AAAA : d)) begin bad++; $display("FAIL wr_port2_same got=%h", rd2); end
    tick(); idle(); #1;
    total++; if (rd2 !== 64'h5555_AAAA_5555_AAAA) begin bad++; $display("FAIL wr_port2_next got=%h want=5555aaaa5555aaaa", rd2); end
  endtask

  task automatic test_x0();
    ra1 = 5'd0; ra2 = 5'd0;
    wb(5'd0, '1); issue_valid = 1'b1; issue_dst = 5'd0; #1;
    total++; if (rd1 !== 64'd0) begin bad++; $display("FAIL x0_same_cycle got=%h want=0", rd1); end
    tick(); idle(); #1;
    total++; if (rd1 !== 64'd0 || rd2 !== 64'd0) begin bad++; $display("FAIL x0_read rd1=%h rd2=%h want 0", rd1, rd2); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL x0_busy got=%b want=0", busy1); end
  endtask

  task automatic test_sb_order();
    ra1 = 5'd7;
    issue_valid = 1'b1; issue_dst = 5'd7; #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL issue_latency got=%b want=0", busy1); end
    tick(); tick(); idle(); #1;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL sb_two_pending got=%b want=1", busy1); end
    wb(5'd7, 64'h77); #1;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL sb_first_wb_cycle got=%b want=1", busy1); end
    tick(); idle(); #1;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL sb_after_first_wb got=%b want=1", busy1); end
    wb(5'd7, 64'h78); #1;
    total++; if (busy1 !== !BYP) begin bad++; $display("FAIL sb_second_wb_cycle got=%b want=%b", busy1, !BYP); end
    tick(); idle(); #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL sb_after_second_wb got=%b want=0", busy1); end
    // extra retire at zero holds the count but still writes
    wb(5'd7, 64'h79); tick(); idle(); #1;
    total++; if (busy1 !== 1'b0 || rd1 !== 64'h79) begin bad++; $display("FAIL sb_retire_at_zero busy=%b rd=%h want 0/79", busy1, rd1); end
  endtask

  task automatic test_simul();
    ra1 = 5'd7;
    issue_valid = 1'b1; issue_dst = 5'd7; tick();
    wb(5'd7, 64'h80); tick(); idle(); #1;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL simul_count_held got=%b want=1", busy1); end
    wb(5'd7, 64'h81); tick(); idle(); #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL simul_drain got=%b want=0", busy1); end
  endtask

  task automatic test_overflow_flush();
    ra2 = 5'd9; ra1 = 5'd10;
    total++; if (sb_overflow !== 1'b0) begin bad++; $display("FAIL ovf_initial got=%b want=0", sb_overflow); end
    issue_valid = 1'b1; issue_dst = 5'd9;
    tick(); tick(); tick(); #1;
    total++; if (sb_overflow !== 1'b0 || busy2 !== 1'b1) begin bad++; $display("FAIL ovf_at_max ovf=%b busy=%b want 0/1", sb_overflow, busy2); end
    tick(); idle(); #1;
    total++; if (sb_overflow !== 1'b1) begin bad++; $display("FAIL ovf_fourth_issue got=%b want=1", sb_overflow); end
    tick(); #1;
    total++; if (sb_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", sb_overflow); end
    flush = 1'b1; wb(5'd10, 64'hF00D); tick(); idle(); #1;
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy2); end
    total++; if (sb_overflow !== 1'b1) begin bad++; $display("FAIL flush_keeps_ovf got=%b want=1", sb_overflow); end
    total++; if (rd1 !== 64'hF00D) begin bad++; $display("FAIL flush_write got=%h want=f00d", rd1); end
  endtask

  task automatic test_async_reset();
    ra1 = 5'd4;
    wb(5'd4, 64'hCAFE); tick(); idle();
    issue_valid = 1'b1; issue_dst = 5'd4; tick(); idle(); #1;
    total++; if (rd1 !== 64'hCAFE || busy1 !== 1'b1) begin bad++; $display("FAIL async_pre rd=%h busy=%b want cafe/1", rd1, busy1); end
    #1 resetn = 1'b0; #1;
    total++; if (rd1 !== 64'd0 || busy1 !== 1'b0) begin bad++; $display("FAIL async_drop rd=%h busy=%b want 0/0", rd1, busy1); end
    total++; if (sb_overflow !== 1'b0) begin bad++; $display("FAIL async_ovf_clear got=%b want=0", sb_overflow); end
    resetn = 1'b1; tick(); #1;
    total++; if (rd1 !== 64'd0 || busy1 !== 1'b0) begin bad++; $display("FAIL async_after rd=%h busy=%b want 0/0", rd1, busy1); end
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    ra1 = '0; ra2 = '0;
    test_reset();
    test_write_read();
    test_x0();
    test_sb_order();
    test_simul();
    test_overflow_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
